// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package dmem_arb_pkg;

  // Arbiter sequencer states
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_t;

  // RV32I load/store funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Requester identifier: 0 = core load/store path, 1 = debug/DMA master
  typedef logic req_id_t;
  localparam req_id_t REQ_CORE = 1'b0;
  localparam req_id_t REQ_DBG  = 1'b1;

  // Number of bytes touched by an access; 0 for encodings that are never legal
  function automatic logic [2:0] access_bytes(input logic [2:0] f3);
    logic [2:0] n;
    case (f3)
      F3_B, F3_BU: n = 3'd1;
      F3_H, F3_HU: n = 3'd2;
      F3_W:        n = 3'd4;
      default:     n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/dmem_req_check.sv
// Combinational legality check of one load/store request (funct3, alignment, range).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; evaluated on whatever request is currently selected.
module dmem_req_check import dmem_arb_pkg::*; #(
  parameter int MEM_BYTES = 256,
  parameter int ADDR_W    = 32
) (
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  output logic              legal
);

  // One extra bit so addr + size never wraps around the top of the address space
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_BYTES);

  logic [2:0]      nbytes;
  logic            f3_ok;
  logic            align_ok;
  logic [ADDR_W:0] end_addr;

  // Legal when the encoding suits the direction, the address is naturally aligned,
  // and the byte past the last accessed one does not exceed the memory size
  always_comb begin
    nbytes   = access_bytes(funct3);
    f3_ok    = 1'b0;
    align_ok = 1'b0;
    case (funct3)
      F3_B:    begin f3_ok = 1'b1; align_ok = 1'b1;               end
      F3_H:    begin f3_ok = 1'b1; align_ok = ~addr[0];           end
      F3_W:    begin f3_ok = 1'b1; align_ok = (addr[1:0] == 2'b00); end
      F3_BU:   begin f3_ok = ~we;  align_ok = 1'b1;               end
      F3_HU:   begin f3_ok = ~we;  align_ok = ~addr[0];           end
      default: begin f3_ok = 1'b0; align_ok = 1'b0;               end
    endcase
    end_addr = {1'b0, addr} + {{(ADDR_W-2){1'b0}}, nbytes};
    legal    = f3_ok && align_ok && (end_addr <= LIMIT);
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer sharing one data-memory port; macro DMEM_ARB_RR_EN selects round-robin ties.
// Latency: accept at edge T, memory access T..T+1, one-cycle response pulse T+1..T+2.
// Backpressure: req_ready only in IDLE for the grantee; losers hold; responses cannot be stalled.
module dmem_arbiter import dmem_arb_pkg::*; #(
  parameter int MEM_BYTES = 256,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req_valid,
  output logic              r0_req_ready,
  input  logic              r0_req_we,
  input  logic [2:0]        r0_req_funct3,
  input  logic [ADDR_W-1:0] r0_req_addr,
  input  logic [DATA_W-1:0] r0_req_wdata,
  output logic              r0_rsp_valid,
  output logic [DATA_W-1:0] r0_rsp_rdata,
  output logic              r0_rsp_err,
  input  logic              r1_req_valid,
  output logic              r1_req_ready,
  input  logic              r1_req_we,
  input  logic [2:0]        r1_req_funct3,
  input  logic [ADDR_W-1:0] r1_req_addr,
  input  logic [DATA_W-1:0] r1_req_wdata,
  output logic              r1_rsp_valid,
  output logic [DATA_W-1:0] r1_rsp_rdata,
  output logic              r1_rsp_err,
  output logic              mem_write,
  output logic              mem_read,
  output logic [2:0]        mem_funct3,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  arb_state_t        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              legal_q, legal_d;
  req_id_t           gnt_q, gnt_d;
`ifdef DMEM_ARB_RR_EN
  req_id_t           prio_q, prio_d;
`endif

  logic              any_vld;
  req_id_t           sel_id;
  logic              sel_we;
  logic [2:0]        sel_f3;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_legal;
  logic              in_access;
  logic              in_resp;

  // Pick the grantee among valid requesters and mux its fields
  always_comb begin
    any_vld = r0_req_valid | r1_req_valid;
`ifdef DMEM_ARB_RR_EN
    if (r0_req_valid && r1_req_valid) sel_id = prio_q;
    else                              sel_id = r1_req_valid ? REQ_DBG : REQ_CORE;
`else
    sel_id = r0_req_valid ? REQ_CORE : (r1_req_valid ? REQ_DBG : REQ_CORE);
`endif
    sel_we    = (sel_id == REQ_DBG) ? r1_req_we     : r0_req_we;
    sel_f3    = (sel_id == REQ_DBG) ? r1_req_funct3 : r0_req_funct3;
    sel_addr  = (sel_id == REQ_DBG) ? r1_req_addr   : r0_req_addr;
    sel_wdata = (sel_id == REQ_DBG) ? r1_req_wdata  : r0_req_wdata;
  end

  dmem_req_check #(
    .MEM_BYTES (MEM_BYTES),
    .ADDR_W    (ADDR_W)
  ) u_check (
    .we     (sel_we),
    .funct3 (sel_f3),
    .addr   (sel_addr),
    .legal  (sel_legal)
  );

  // Sequencer next state: latch the granted request, run one access, emit one response
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    legal_d = legal_q;
    gnt_d   = gnt_q;
`ifdef DMEM_ARB_RR_EN
    prio_d  = prio_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (any_vld) begin
          we_d    = sel_we;
          f3_d    = sel_f3;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          legal_d = sel_legal;
          gnt_d   = sel_id;
`ifdef DMEM_ARB_RR_EN
          prio_d  = ~sel_id;
`endif
          state_d = ARB_ACCESS;
        end
      end
      ARB_ACCESS: begin
        rdata_d = (legal_q && !we_q) ? mem_read_data : '0;
        state_d = ARB_RESP;
      end
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  // State and latched request registers; reset discards any pending transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      legal_q <= 1'b0;
      gnt_q   <= REQ_CORE;
`ifdef DMEM_ARB_RR_EN
      prio_q  <= REQ_CORE;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      legal_q <= legal_d;
      gnt_q   <= gnt_d;
`ifdef DMEM_ARB_RR_EN
      prio_q  <= prio_d;
`endif
    end
  end

  // Outputs decoded from registered state so strobes vanish as soon as reset hits
  always_comb begin
    in_access      = (state_q == ARB_ACCESS);
    in_resp        = (state_q == ARB_RESP);
    r0_req_ready   = (state_q == ARB_IDLE) && any_vld && (sel_id == REQ_CORE);
    r1_req_ready   = (state_q == ARB_IDLE) && any_vld && (sel_id == REQ_DBG);
    mem_write      = in_access && legal_q && we_q;
    mem_read       = in_access && legal_q && !we_q;
    mem_funct3     = in_access ? f3_q    : 3'b000;
    mem_address    = in_access ? addr_q  : '0;
    mem_write_data = in_access ? wdata_q : '0;
    r0_rsp_valid   = in_resp && (gnt_q == REQ_CORE);
    r1_rsp_valid   = in_resp && (gnt_q == REQ_DBG);
    r0_rsp_err     = r0_rsp_valid && !legal_q;
    r1_rsp_err     = r1_rsp_valid && !legal_q;
    r0_rsp_rdata   = r0_rsp_valid ? rdata_q : '0;
    r1_rsp_rdata   = r1_rsp_valid ? rdata_q : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-addressed behavioural memory behind it.
// Latency: checks accept-to-response of 2 cycles and one request per 3 cycles.
// Backpressure: holds requests until ready; exercises ties, reset mid-access, illegal requests.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_req_valid, r0_req_ready, r0_req_we, r0_rsp_valid, r0_rsp_err;
  logic [2:0]  r0_req_funct3;
  logic [31:0] r0_req_addr, r0_req_wdata, r0_rsp_rdata;
  logic        r1_req_valid, r1_req_ready, r1_req_we, r1_rsp_valid, r1_rsp_err;
  logic [2:0]  r1_req_funct3;
  logic [31:0] r1_req_addr, r1_req_wdata, r1_rsp_rdata;
  logic        mem_write, mem_read;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_address, mem_write_data, mem_read_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_BYTES(256), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready), .r0_req_we(r0_req_we),
    .r0_req_funct3(r0_req_funct3), .r0_req_addr(r0_req_addr), .r0_req_wdata(r0_req_wdata),
    .r0_rsp_valid(r0_rsp_valid), .r0_rsp_rdata(r0_rsp_rdata), .r0_rsp_err(r0_rsp_err),
    .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready), .r1_req_we(r1_req_we),
    .r1_req_funct3(r1_req_funct3), .r1_req_addr(r1_req_addr), .r1_req_wdata(r1_req_wdata),
    .r1_rsp_valid(r1_rsp_valid), .r1_rsp_rdata(r1_rsp_rdata), .r1_rsp_err(r1_rsp_err),
    .mem_write(mem_write), .mem_read(mem_read), .mem_funct3(mem_funct3),
    .mem_address(mem_address), .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  // Behavioural single-cycle data memory: combinational read with extension, write on edge
  logic [7:0] mem [0:255];
  logic [7:0] a0, a1, a2, a3;
  initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;

  always_comb begin
    a0 = mem_address[7:0];
    a1 = a0 + 8'd1;
    a2 = a0 + 8'd2;
    a3 = a0 + 8'd3;
    case (mem_funct3)
      3'b000:  mem_read_data = {{24{mem[a0][7]}}, mem[a0]};
      3'b001:  mem_read_data = {{16{mem[a1][7]}}, mem[a1], mem[a0]};
      3'b010:  mem_read_data = {mem[a3], mem[a2], mem[a1], mem[a0]};
      3'b100:  mem_read_data = {24'h0, mem[a0]};
      3'b101:  mem_read_data = {16'h0, mem[a1], mem[a0]};
      default: mem_read_data = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (mem_write) begin
      mem[a0] <= mem_write_data[7:0];
      if (mem_funct3 == 3'b001 || mem_funct3 == 3'b010) mem[a1] <= mem_write_data[15:8];
      if (mem_funct3 == 3'b010) begin
        mem[a2] <= mem_write_data[23:16];
        mem[a3] <= mem_write_data[31:24];
      end
    end
  end

  typedef struct {
    int          id;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int id, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err);
    vec_t v;
    v.id = id; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_rd = exp_rd; v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input int id, input logic v, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    if (id == 1) begin
      r1_req_valid = v; r1_req_we = we; r1_req_funct3 = f3; r1_req_addr = a; r1_req_wdata = d;
    end else begin
      r0_req_valid = v; r0_req_we = we; r0_req_funct3 = f3; r0_req_addr = a; r0_req_wdata = d;
    end
  endtask

  function automatic logic rdy(input int id);
    return (id == 1) ? r1_req_ready : r0_req_ready;
  endfunction
  function automatic logic rspv(input int id);
    return (id == 1) ? r1_rsp_valid : r0_rsp_valid;
  endfunction
  function automatic logic [31:0] rspd(input int id);
    return (id == 1) ? r1_rsp_rdata : r0_rsp_rdata;
  endfunction
  function automatic logic rspe(input int id);
    return (id == 1) ? r1_rsp_err : r0_rsp_err;
  endfunction

  // Issue one request from a negedge, follow it through ACCESS and RESP, end on a negedge
  task automatic run_req(input string nm, input vec_t v);
    int n = 0;
    drive(v.id, 1'b1, v.we, v.f3, v.addr, v.wdata);
    #1;
    while (!rdy(v.id) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk({nm, " ready"}, rdy(v.id), 1'b1);
    if (!rdy(v.id)) begin
      drive(v.id, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      return;
    end
    @(posedge clk); #1;
    drive(v.id, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    chk({nm, " access rsp_valid"}, rspv(v.id), 1'b0);
    chk({nm, " mem_write"}, mem_write, !v.exp_err && v.we);
    chk({nm, " mem_read"},  mem_read,  !v.exp_err && !v.we);
    @(negedge clk);
    chk({nm, " rsp_valid"}, rspv(v.id), 1'b1);
    chk({nm, " rsp_rdata"}, rspd(v.id), v.exp_rd);
    chk({nm, " rsp_err"},   rspe(v.id), v.exp_err);
    @(negedge clk);
    chk({nm, " rsp pulse"}, rspv(v.id), 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   order[$];
    int   exp_order[8];
    int   t_acc[$];
    int   t_rsp[$];
    int   c0;
    int   c1;
    logic g0;
    logic g1;
    logic both;
    logic seen;
    int   n;

    // Directed vectors: {id, we, funct3, addr, wdata, expected rdata, expected err}
    add(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0); // SW
    add(0, 1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0); // LW
    add(1, 1'b0, 3'b001, 32'h11, 32'h0,        32'h0,        1'b1); // LH misaligned
    add(0, 1'b0, 3'b010, 32'hFE, 32'h0,        32'h0,        1'b1); // LW misaligned
    add(1, 1'b1, 3'b100, 32'h40, 32'h55,       32'h0,        1'b1); // store with load-only funct3
    add(0, 1'b1, 3'b000, 32'h20, 32'h80,       32'h0,        1'b0); // SB
    add(0, 1'b0, 3'b000, 32'h20, 32'h0,        32'hFFFFFF80, 1'b0); // LB sign-extends
    add(1, 1'b0, 3'b100, 32'h20, 32'h0,        32'h00000080, 1'b0); // LBU zero-extends
    add(0, 1'b1, 3'b010, 32'h30, 32'hCAFEF00D, 32'h0,        1'b0); // SW prior contents
    add(1, 1'b0, 3'b001, 32'h10, 32'h0,        32'hFFFFBEEF, 1'b0); // LH low half
    add(0, 1'b0, 3'b101, 32'h12, 32'h0,        32'h0000DEAD, 1'b0); // LHU high half
    add(1, 1'b1, 3'b010, 32'hFC, 32'h0BADCAFE, 32'h0,        1'b0); // SW last legal word
    add(1, 1'b0, 3'b010, 32'hFC, 32'h0,        32'h0BADCAFE, 1'b0); // LW last legal word
    add(0, 1'b0, 3'b000, 32'h100, 32'h0,       32'h0,        1'b1); // LB out of range
    add(0, 1'b1, 3'b001, 32'hFF, 32'h1234,     32'h0,        1'b1); // SH misaligned at top
    add(0, 1'b1, 3'b000, 32'hFF, 32'h5A,       32'h0,        1'b0); // SB last byte
    add(0, 1'b0, 3'b100, 32'hFF, 32'h0,        32'h0000005A, 1'b0); // LBU last byte
    add(0, 1'b0, 3'b011, 32'h0,  32'h0,        32'h0,        1'b1); // reserved funct3
    add(1, 1'b0, 3'b000, 32'hFFFFFFFF, 32'h0,  32'h0,        1'b1); // LB far out of range

    drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    rst = 1'b1;
    #3;
    chk("reset r0_req_ready", r0_req_ready, 1'b0);
    chk("reset r1_req_ready", r1_req_ready, 1'b0);
    chk("reset rsp_valid",    {r0_rsp_valid, r1_rsp_valid}, 2'b00);
    chk("reset rsp_err",      {r0_rsp_err, r1_rsp_err}, 2'b00);
    chk("reset r0_rsp_rdata", r0_rsp_rdata, 32'h0);
    chk("reset r1_rsp_rdata", r1_rsp_rdata, 32'h0);
    chk("reset mem strobes",  {mem_write, mem_read}, 2'b00);
    chk("reset mem_address",  mem_address, 32'h0);
    chk("reset mem_funct3",   {29'h0, mem_funct3}, 32'h0);
    chk("reset mem_write_data", mem_write_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      run_req($sformatf("vec%0d", i), v);
    end

    // Reset during the ACCESS cycle of a store: not written, no response
    drive(0, 1'b1, 1'b1, 3'b010, 32'h30, 32'h12345678);
    #1;
    n = 0;
    while (!r0_req_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("rstmid ready", r0_req_ready, 1'b1);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #1;
    chk("rstmid pre mem_write", mem_write, 1'b1);
    rst = 1'b1;
    #1;
    chk("rstmid mem strobes", {mem_write, mem_read}, 2'b00);
    chk("rstmid mem_address", mem_address, 32'h0);
    chk("rstmid mem_write_data", mem_write_data, 32'h0);
    chk("rstmid rsp_valid", {r0_rsp_valid, r1_rsp_valid}, 2'b00);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (r0_rsp_valid || r1_rsp_valid) seen = 1'b1;
    end
    chk("rstmid no response", seen, 1'b0);
    v.id = 0; v.we = 1'b0; v.f3 = 3'b010; v.addr = 32'h30; v.wdata = 32'h0;
    v.exp_rd = 32'hCAFEF00D; v.exp_err = 1'b0;
    run_req("rstmid readback", v);

    // Tie: both requesters hold valid for four loads each
`ifdef DMEM_ARB_RR_EN
    exp_order = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0, 1, 1, 1, 1};
`endif
    do_reset();
    c0 = 0; c1 = 0; both = 1'b0;
    drive(0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    drive(1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    for (int i = 0; i < 60 && order.size() < 8; i++) begin
      #1;
      if (r0_req_ready && r1_req_ready) both = 1'b1;
      g0 = r0_req_valid && r0_req_ready;
      g1 = r1_req_valid && r1_req_ready;
      if (g0) begin order.push_back(0); c0++; end
      if (g1) begin order.push_back(1); c1++; end
      if (g0 || g1) begin
        @(posedge clk); #1;
        if (c0 == 4) r0_req_valid = 1'b0;
        if (c1 == 4) r1_req_valid = 1'b0;
      end
      @(negedge clk);
    end
    drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    chk("tie single grant", both, 1'b0);
    chk("tie grant count", order.size(), 8);
    for (int k = 0; k < order.size() && k < 8; k++)
      chk($sformatf("tie grant %0d", k), order[k], exp_order[k]);

    // Back-to-back: r0 keeps valid high across three loads
    drive(0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    for (int i = 0; i < 14; i++) begin
      #1;
      if (r0_rsp_valid) begin
        t_rsp.push_back(i);
        chk($sformatf("b2b rdata %0d", t_rsp.size()), r0_rsp_rdata, 32'hDEADBEEF);
      end
      if (r0_req_valid && r0_req_ready) begin
        t_acc.push_back(i);
        if (t_acc.size() == 3) begin
          @(posedge clk); #1;
          r0_req_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    chk("b2b accept count", t_acc.size(), 3);
    chk("b2b response count", t_rsp.size(), 3);
    for (int k = 1; k < t_acc.size(); k++)
      chk($sformatf("b2b accept gap %0d", k), t_acc[k] - t_acc[k-1], 3);
    for (int k = 0; k < t_acc.size() && k < t_rsp.size(); k++)
      chk($sformatf("b2b latency %0d", k), t_rsp[k] - t_acc[k], 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
